// File: rtl/reg_op_pkg.sv
// Shared definitions for the register-operations block and its command sequencer:
// default widths, sequencer state encoding and the operation select codes.
package reg_op_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int SEL_W_DEF  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  // Select codes understood by the register-operations block; code 0 doubles as the idle select
  localparam logic [1:0] SEL_OP0  = 2'b00;
  localparam logic [1:0] SEL_OP1  = 2'b01;
  localparam logic [1:0] SEL_OP2  = 2'b10;
  localparam logic [1:0] SEL_OP3  = 2'b11;
  localparam logic [1:0] SEL_IDLE = SEL_OP0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data, synchronous flush
// and an occupancy count one bit wider than the pointers.
module sync_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_cmd_sequencer.sv
// Command stage for the register-operations block: buffers {data, sel} words and
// replays them in order, holding each on in_out/s_out for hold_cycles+1 cycles.
module reg_cmd_sequencer import reg_op_pkg::*; #(
  parameter int               DATA_W   = DATA_W_DEF,
  parameter int               SEL_W    = SEL_W_DEF,
  parameter int               DEPTH    = 8,
  parameter int               HOLD_W   = 4,
  parameter logic [SEL_W-1:0] IDLE_SEL = SEL_W'(SEL_IDLE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [DATA_W+SEL_W-1:0]   cmd_data,
  input  logic                      start,
  input  logic                      abort,
  input  logic [HOLD_W-1:0]         hold_cycles,
  output logic [DATA_W-1:0]         in_out,
  output logic [SEL_W-1:0]          s_out,
  output logic                      issue,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(DEPTH):0]    count
);

  seq_state_t                state;
  seq_state_t                state_next;
  logic [DATA_W+SEL_W-1:0]   fifo_rdata;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic [HOLD_W-1:0]         hold_cnt;
  logic [HOLD_W-1:0]         hold_load;
  logic [HOLD_W-1:0]         hold_next;
  logic [HOLD_W-1:0]         hold_load_next;
  logic [DATA_W-1:0]         in_next;
  logic [SEL_W-1:0]          s_next;
  logic                      issue_next;
  logic                      done_next;

  // abort flushes the FIFO this edge, so a concurrent push must not land
  assign cmd_ready = ~fifo_full;
  assign push      = cmd_valid & cmd_ready & ~abort;

  sync_fifo #(
    .WIDTH (DATA_W + SEL_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (abort),
    .wdata (cmd_data),
    .rdata (fifo_rdata),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (start && !fifo_empty) state_next = RUN;
        RUN:  if (hold_cnt == '0 && fifo_empty) state_next = IDLE;
      endcase
    end
  end

  // Next values for the registered outputs; the FWFT head is loaded on the same edge it is popped
  always_comb begin
    pop            = 1'b0;
    in_next        = in_out;
    s_next         = s_out;
    issue_next     = 1'b0;
    done_next      = 1'b0;
    hold_next      = hold_cnt;
    hold_load_next = hold_load;
    if (abort) begin
      in_next   = '0;
      s_next    = IDLE_SEL;
      hold_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !fifo_empty) begin
            pop               = 1'b1;
            {in_next, s_next} = fifo_rdata;
            hold_next         = hold_cycles;
            hold_load_next    = hold_cycles;
            issue_next        = 1'b1;
          end
        end
        RUN: begin
          if (hold_cnt != '0) begin
            hold_next = hold_cnt - HOLD_W'(1);
          end else if (!fifo_empty) begin
            pop               = 1'b1;
            {in_next, s_next} = fifo_rdata;
            hold_next         = hold_load;
            issue_next        = 1'b1;
          end else begin
            in_next   = '0;
            s_next    = IDLE_SEL;
            done_next = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_out    <= '0;
      s_out     <= IDLE_SEL;
      issue     <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      hold_cnt  <= '0;
      hold_load <= '0;
    end else begin
      in_out    <= in_next;
      s_out     <= s_next;
      issue     <= issue_next;
      done      <= done_next;
      busy      <= (state_next == RUN);
      hold_cnt  <= hold_next;
      hold_load <= hold_load_next;
    end
  end

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Self-checking bench for reg_cmd_sequencer: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_reg_cmd_sequencer;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [5:0] cmd_data = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] hold_cycles = '0;
  logic       cmd_ready;
  logic [3:0] in_out;
  logic [1:0] s_out;
  logic       issue;
  logic       busy;
  logic       done;
  logic [3:0] count;

  int assertCount = 0;
  int failCount = 0;
  bit checkEnable = 1'b0;

  logic [5:0] words [8] = '{6'b1010_00, 6'b0110_01, 6'b1010_10, 6'b0101_11,
                            6'b1111_10, 6'b0001_01, 6'b0011_11, 6'b1110_00};

  // Reference model: a queue of pending commands plus the word currently presented
  logic [5:0] mq [$];
  logic [3:0] mIn;
  logic [1:0] mS;
  bit         mIssue;
  bit         mDone;
  bit         mRunning;
  int         mRemain;
  int         mLatched;
  bit         mPushOk;

  int firstIssue, secondIssue, doneAt, doneCount, nIssued;
  bit doneSeen;

  reg_cmd_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .start       (start),
    .abort       (abort),
    .hold_cycles (hold_cycles),
    .in_out      (in_out),
    .s_out       (s_out),
    .issue       (issue),
    .busy        (busy),
    .done        (done),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [5:0] d, input bit st,
                               input bit ab, input logic [3:0] h);
    @(negedge clk);
    cmd_valid   = v;
    cmd_data    = d;
    start       = st;
    abort       = ab;
    hold_cycles = h;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      mIn = '0; mS = '0; mIssue = 0; mDone = 0; mRunning = 0; mRemain = 0; mLatched = 0;
    end else begin
      mPushOk = cmd_valid && (mq.size() < DEPTH);
      mIssue = 0;
      mDone = 0;
      if (abort) begin
        mq.delete();
        mIn = '0; mS = '0; mRunning = 0; mRemain = 0;
      end else begin
        if (!mRunning) begin
          if (start && mq.size() > 0) begin
            {mIn, mS} = mq.pop_front();
            mRemain = hold_cycles;
            mLatched = hold_cycles;
            mRunning = 1;
            mIssue = 1;
          end
        end else if (mRemain > 0) begin
          mRemain--;
        end else if (mq.size() > 0) begin
          {mIn, mS} = mq.pop_front();
          mRemain = mLatched;
          mIssue = 1;
        end else begin
          mIn = '0; mS = '0; mDone = 1; mRunning = 0;
        end
        if (mPushOk) mq.push_back(cmd_data);
      end
    end
  end

  always @(negedge clk) begin
    if (checkEnable && reset) begin
      checkOutput("model_in_out", in_out, mIn);
      checkOutput("model_s_out", s_out, mS);
      checkOutput("model_issue", issue, mIssue);
      checkOutput("model_done", done, mDone);
      checkOutput("model_busy", busy, mRunning);
      checkOutput("model_count", count, mq.size());
      checkOutput("model_cmd_ready", cmd_ready, (mq.size() < DEPTH) ? 1 : 0);
    end
  end

  initial begin
    #3 reset = 1'b0;
    #1;
    checkOutput("reset_in_out", in_out, 0);
    checkOutput("reset_s_out", s_out, 0);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_issue", issue, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_cmd_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    checkEnable = 1'b1;

    // Basic run, hold 0
    for (int i = 0; i < 8; i++) applyStimulus(1, words[i], 0, 0, 0);
    applyStimulus(0, '0, 1, 0, 0);
    checkOutput("t1_count_before_start", count, 8);
    applyStimulus(0, '0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("t1_in_out", in_out, words[i][5:2]);
      checkOutput("t1_s_out", s_out, words[i][1:0]);
      checkOutput("t1_issue", issue, 1);
    end
    @(negedge clk);
    checkOutput("t1_done", done, 1);
    checkOutput("t1_end_in_out", in_out, 0);
    checkOutput("t1_end_s_out", s_out, 0);
    checkOutput("t1_end_busy", busy, 0);
    @(negedge clk);
    checkOutput("t1_done_one_cycle", done, 0);

    // Hold timing, hold 2
    applyStimulus(1, words[0], 0, 0, 2);
    applyStimulus(1, words[1], 0, 0, 2);
    applyStimulus(0, '0, 1, 0, 2);
    applyStimulus(0, '0, 0, 0, 2);
    firstIssue = -1; secondIssue = -1; doneAt = -1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      if (issue) begin
        if (firstIssue < 0) firstIssue = c;
        else if (secondIssue < 0) secondIssue = c;
      end
      if (done && doneAt < 0) doneAt = c;
      if (c == 2) checkOutput("t2_held_word0", in_out, 4'b1010);
      if (c == 5) checkOutput("t2_held_word1", in_out, 4'b0110);
    end
    checkOutput("t2_first_issue", firstIssue, 0);
    checkOutput("t2_second_issue", secondIssue, 3);
    checkOutput("t2_done_at", doneAt, 6);

    // Full / backpressure: ninth word dropped
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, (i < 8) ? words[i] : 6'b111111, 0, 0, 0);
      if (i == 8) checkOutput("t3_cmd_ready_full", cmd_ready, 0);
    end
    applyStimulus(0, '0, 1, 0, 0);
    checkOutput("t3_count_full", count, 8);
    applyStimulus(0, '0, 0, 0, 0);
    nIssued = 0; doneSeen = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (issue) begin
        if (nIssued < 8) checkOutput("t3_replay_word", {in_out, s_out}, words[nIssued]);
        nIssued++;
      end
      if (done) doneSeen = 1;
    end
    checkOutput("t3_issue_count", nIssued, 8);
    checkOutput("t3_done_seen", doneSeen, 1);

    // Streaming: push coincides with the first pop
    applyStimulus(1, 6'b0110_01, 0, 0, 1);
    applyStimulus(1, 6'b0011_11, 1, 0, 1);
    applyStimulus(0, '0, 0, 0, 1);
    checkOutput("t4_count_unchanged", count, 1);
    firstIssue = -1; secondIssue = -1; doneAt = -1; doneCount = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      if (issue) begin
        if (firstIssue < 0) firstIssue = c;
        else if (secondIssue < 0) secondIssue = c;
      end
      if (c == 2) checkOutput("t4_second_word", {in_out, s_out}, 6'b0011_11);
      if (done) begin
        doneCount++;
        if (doneAt < 0) doneAt = c;
      end
    end
    checkOutput("t4_first_issue", firstIssue, 0);
    checkOutput("t4_second_issue", secondIssue, 2);
    checkOutput("t4_done_at", doneAt, 4);
    checkOutput("t4_done_count", doneCount, 1);

    // Abort during the third command
    for (int i = 0; i < 8; i++) applyStimulus(1, words[i], 0, 0, 1);
    applyStimulus(0, '0, 1, 0, 1);
    applyStimulus(0, '0, 0, 0, 1);
    repeat (4) @(negedge clk);
    checkOutput("t5_third_cmd", in_out, 4'b1010);
    checkOutput("t5_third_sel", s_out, 2'b10);
    applyStimulus(0, '0, 0, 1, 1);
    applyStimulus(1, 6'b010101, 0, 0, 1);
    checkOutput("t5_count", count, 0);
    checkOutput("t5_in_out", in_out, 0);
    checkOutput("t5_s_out", s_out, 0);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_issue", issue, 0);
    applyStimulus(0, '0, 0, 0, 1);
    doneSeen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) doneSeen = 1;
    end
    checkOutput("t5_no_done", doneSeen, 0);
    checkOutput("t5_busy_after", busy, 0);

    // Asynchronous reset between clock edges
    for (int i = 0; i < 3; i++) applyStimulus(1, words[i], 0, 0, 3);
    applyStimulus(0, '0, 1, 0, 3);
    applyStimulus(0, '0, 0, 0, 3);
    checkOutput("t6_running_before_reset", busy, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("t6_async_in_out", in_out, 0);
    checkOutput("t6_async_s_out", s_out, 0);
    checkOutput("t6_async_busy", busy, 0);
    checkOutput("t6_async_count", count, 0);
    checkOutput("t6_async_issue", issue, 0);
    @(negedge clk);
    reset = 1'b1;

    // Start with an empty FIFO is ignored
    applyStimulus(0, '0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, '0, 0, 0, 0);
      checkOutput("t7_busy", busy, 0);
      checkOutput("t7_issue", issue, 0);
      checkOutput("t7_done", done, 0);
    end

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(0, 1) == 1), 6'($urandom), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 49) == 0), 4'($urandom_range(0, 3)));
    end
    for (int k = 0; k < 60; k++) applyStimulus(0, '0, 0, 0, 0);

    checkEnable = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/reg_cmd_sequencer.md
Name: reg_cmd_sequencer

Overview:
- Upstream command stage for the 4-bit register-operations block.
- Buffers {data, select} command words in a small FIFO and replays them in order on start.
- Holds each command on the downstream in/s inputs for a programmable number of cycles.
- Signals each new issue and end-of-program, so sequences come from a host instead of a hand-timed bench.

Parameters:
- DATA_W, 4, width of data word driven to the downstream in input
- SEL_W, 2, width of operation select driven to the downstream s input
- DEPTH, 8, FIFO entries (power of 2, >=2)
- HOLD_W, 4, width of hold_cycles
- IDLE_SEL, 2'b00, select value driven when no command is active

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  host has a command
- cmd_ready  out  1  FIFO can accept (not full)
- cmd_data  in  DATA_W+SEL_W  packed {data, sel}; data in upper bits
- start  in  1  begin replay (sampled in IDLE only)
- abort  in  1  stop run and flush FIFO
- hold_cycles  in  HOLD_W  extra cycles each command is held
- in_out  out  DATA_W  to downstream in
- s_out  out  SEL_W  to downstream s
- issue  out  1  one-cycle pulse: in_out/s_out just took a new command
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse at end of program
- count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (reset=0, async) clears:
  - FIFO pointers, count=0
  - state=IDLE
  - in_out=0, s_out=IDLE_SEL
  - issue=0, done=0, busy=0, hold counter=0
- Reset asserted mid-run aborts immediately. Stored commands are lost.
- All outputs are registered.
- FIFO:
  - push = cmd_valid & cmd_ready
  - cmd_ready = (count != DEPTH), in any state
  - Push when full is dropped and nothing changes.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- States: IDLE, RUN.
- IDLE:
  - start=1 with count>0 at edge T: pop head into in_out/s_out, latch hold_cycles into hold counter, issue=1 for the cycle after T, go to RUN.
  - start with count=0 is ignored (no done pulse).
  - Outputs stay at in_out=0, s_out=IDLE_SEL.
- RUN, at each edge:
  - If hold counter != 0: decrement it; outputs unchanged, issue=0.
  - Else if count>0: pop next command to the outputs, reload the counter from the hold value latched at start, issue=1.
  - Else: in_out=0, s_out=IDLE_SEL, done=1 for one cycle, go to IDLE.
- Each command therefore occupies exactly hold_cycles+1 cycles.
- hold_cycles changes during RUN are ignored.
- Pushes during RUN are appended and replayed in the same run (streaming), as long as they arrive before the FIFO drains.
- abort=1 at an edge, any state:
  - FIFO flushed (count=0), outputs to idle values, state=IDLE, issue=0.
  - No done pulse.
  - abort has priority over start and push in that cycle.
- start while in RUN is ignored.
- busy = (state==RUN).

Decomposition:
- Shared package reg_op_pkg holds:
  - the state encoding (IDLE, RUN)
  - DATA_W, SEL_W defaults
  - the select encodings shared with the register-operations block, including the IDLE_SEL value
- One natural sub-module: sync_fifo, parameterised by width and DEPTH.
  - Ports: push, pop, flush, wdata, rdata, count, full, empty.
  - Read data is first-word-fall-through so a pop and the output load happen on the same edge.

Test Plan:
- Reset and basic run:
  - Stimulus: reset low, then release. Push 8 words in order: {1010,00}, {0110,01}, {1010,10}, {0101,11}, {1111,10}, {0001,01}, {0011,11}, {1110,00}. hold_cycles=0, then start.
  - Response: count=8 before start. in_out/s_out step through the 8 words on 8 consecutive cycles with issue=1 on each. Then in_out=0000, s_out=00, done=1 for 1 cycle, busy=0.
- Hold timing:
  - Stimulus: push {1010,00}, {0110,01}; hold_cycles=2; start.
  - Response: each word is held exactly 3 cycles. issue pulses are 3 cycles apart. done comes 6 cycles after the first issue.
- Full/backpressure:
  - Stimulus: push 9 words in IDLE.
  - Response: cmd_ready=0 after the 8th, 9th word dropped, count=8. Replay shows only the first 8 words.
- Streaming and simultaneous push/pop:
  - Stimulus: push 1 word, start with hold_cycles=1. Push {0011,11} in the same cycle as a pop.
  - Response: count is unchanged that cycle. The second word issues with no gap. Single done pulse at the end.
- Abort and async reset:
  - Stimulus: abort during the 3rd command of an 8-word run.
  - Response: next cycle count=0, in_out=0, s_out=00, busy=0, and done never asserts.
  - Stimulus: assert reset mid-run between clock edges.
  - Response: outputs clear immediately, without waiting for a clock edge.
- Empty start:
  - Stimulus: start with count=0.
  - Response: stays IDLE, and busy, issue and done all remain 0.
